bus_master_arbiter: RTL and testbench
=====================================

# bus_master_arbiter

Round-robin arbiter and master sequencer for the dValid/dAck byte bus. Accepts transfer requests from up to N_REQ local requesters, selects one, and drives dValid/data onto the bus under the bus protocol: dValid high 2–4 clocks, data stable and known throughout, dValid de-asserted the clock after dAck, at least one low clock between transfers. Sits between the requesters and the bus target; the bus protocol checkers bind directly to its bus-side ports.

## Interface
- N_REQ, 4, number of requesters (2..8)
- DATA_W, 8, bus data width
- MAX_VALID, 4, maximum dValid-high clocks per transfer (timeout bound)
- MIN_VALID, 2, first dValid cycle index in which dAck is accepted

- clk  in  1  bus clock, all logic on posedge
- reset  in  1  synchronous, active-low reset
- req  in  N_REQ  per-requester transfer request, level
- req_data  in  N_REQ*DATA_W  per-requester payload, slice i = bits [i*DATA_W +: DATA_W]
- gnt  out  N_REQ  one-hot, one-cycle pulse in first dValid cycle of that requester's transfer
- done  out  N_REQ  one-hot, one-cycle pulse when transfer ends by dAck
- timeout  out  N_REQ  one-hot, one-cycle pulse when transfer ends without dAck
- dValid  out  1  bus valid
- data  out  DATA_W  bus data
- dAck  in  1  target acknowledge
- early_ack  out  1  sticky flag: dAck seen in dValid cycle 1; cleared only by reset

## Operation
- States: IDLE, XFER. All outputs registered.
- IDLE: dValid=0, data=0. If any req high at a posedge: pick winner i by round-robin from pointer rr; next cycle XFER with dValid=1, data=req_data[i] (captured), gnt[i]=1, vcnt=1, rr=(i+1) mod N_REQ.
- Round-robin: search starts at rr, wraps at N_REQ-1 -> 0; pointer advances only on grant.
- XFER: data held constant; vcnt counts dValid cycles 1..MAX_VALID.
- dAck sampled high with vcnt>=MIN_VALID: next cycle IDLE, dValid=0, done[i]=1.
- dAck sampled high with vcnt<MIN_VALID: ignored for completion, early_ack set; transfer continues.
- vcnt==MAX_VALID and no dAck: next cycle IDLE, dValid=0, timeout[i]=1.
- dAck while IDLE: ignored.
- req ignored during XFER; requester must drop req in the cycle after seeing gnt (transfer length ≥2 guarantees it is not re-granted).
- vcnt width: clog2(MAX_VALID+1).

## Timing
- Reset (reset low at posedge): next cycle state=IDLE, dValid=0, data=0, gnt=done=timeout=0, early_ack=0, rr=0, vcnt=0. Applies mid-transfer: dValid drops immediately, no done/timeout issued.
- Request-to-dValid latency: 1 clock from the posedge sampling req.
- dValid high length: k clocks where dAck sampled in vcnt=k (2..MAX_VALID), else exactly MAX_VALID.
- dValid always low ≥1 clock between transfers; back-to-back: exactly 1 low clock.
- done/timeout asserted in the first dValid-low cycle; gnt in the first dValid-high cycle.
- dAck in vcnt=1 and again in vcnt=2: early_ack set, transfer ends by done after vcnt=2.

## Structure
- Package bus_master_pkg: state enum (IDLE, XFER), default DATA_W/MAX_VALID/MIN_VALID constants.
- Sub-module rr_picker: combinational round-robin selector (req, rr pointer -> one-hot winner, valid); rest in top.

## Test plan
- Single req[0], data 0xA5, dAck high in vcnt=2 -> dValid high 2 clocks, data=0xA5 throughout, gnt[0] in cycle 1, done[0] the cycle dValid falls.
- req[1] with dAck never asserted -> dValid high exactly 4 clocks, timeout[1] pulse, no done, dValid low next.
- req[0..3] all high continuously with dAck in vcnt=3 -> grant order 0,1,2,3,0; exactly 1 low clock between transfers; data matches each requester's payload.
- dAck high in vcnt=1 and vcnt=2 -> early_ack sets and stays 1, transfer completes after 2 cycles with done.
- reset low during vcnt=2 -> dValid=0, data=0 next clock, no done/timeout, rr=0; next request granted to requester 0 first.
- dAck pulses while IDLE, no req -> no bus activity, all pulses 0.

Source files
------------

// File: rtl/bus_master_arbiter_pkg.sv
// Shared definitions for the dValid/dAck bus master arbiter.
//   - FSM state constants (IDLE, XFER)
//   - default DATA_W / MAX_VALID / MIN_VALID / N_REQ constants
//   - next_rr(): round-robin pointer advance with wrap
package bus_master_pkg;

    // Two-state sequencer, kept as plain constants for legacy tools.
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] XFER = 1'b1;

    localparam int unsigned DEF_N_REQ     = 4;
    localparam int unsigned DEF_DATA_W    = 8;
    localparam int unsigned DEF_MAX_VALID = 4;
    localparam int unsigned DEF_MIN_VALID = 2;

    // Pointer to the requester after idx, wrapping n_req-1 -> 0.
    function automatic int unsigned next_rr(input int unsigned idx, input int unsigned n_req);
        return (idx + 1 == n_req) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/bus_master_arbiter_if.sv
// Bus-side signals of the dValid/dAck byte bus.
//   dValid : master -> target, transfer valid
//   data   : master -> target, payload, stable while dValid is high
//   dAck   : target -> master, acknowledge
// Modports: master (arbiter side), slave (target / protocol checker side).
interface bus_master_arbiter_if #(
    parameter int unsigned DATA_W = 8
);
    logic              dValid;
    logic [DATA_W-1:0] data;
    logic              dAck;

    modport master (output dValid, output data, input dAck);
    modport slave  (input dValid, input data, output dAck);
endinterface

// File: rtl/bus_master_arbiter_rr_picker.sv
// Combinational round-robin selector.
//   req    : request vector
//   ptr    : index with highest priority this round
//   valid  : at least one request present
//   idx    : winning requester index
//   onehot : winning requester as a one-hot vector
module rr_picker #(
    parameter int unsigned N_REQ = 4,
    localparam int unsigned IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             valid,
    output logic [IDX_W-1:0] idx,
    output logic [N_REQ-1:0] onehot
);

    always_comb begin
        int unsigned cand;
        valid  = 1'b0;
        idx    = '0;
        onehot = '0;
        cand   = 0;
        // Walk offsets from the far end back to ptr so the closest hit wins.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = (int'(ptr) + k) % N_REQ;
            if (req[cand]) begin
                valid        = 1'b1;
                idx          = IDX_W'(cand);
                onehot       = '0;
                onehot[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_master_arbiter.sv
// Round-robin arbiter and master sequencer for the dValid/dAck byte bus.
//   clk       : bus clock
//   reset     : synchronous active-low reset
//   req       : per-requester level request
//   req_data  : per-requester payload, slice i = [i*DATA_W +: DATA_W]
//   gnt       : one-hot pulse in the first dValid cycle of a transfer
//   done      : one-hot pulse in the first low cycle after an acked transfer
//   timeout   : one-hot pulse in the first low cycle after an unacked transfer
//   early_ack : sticky, dAck seen before MIN_VALID; cleared only by reset
//   bus       : dValid/data out, dAck in
module bus_master_arbiter
    import bus_master_pkg::*;
#(
    parameter int unsigned N_REQ     = DEF_N_REQ,
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned MAX_VALID = DEF_MAX_VALID,
    parameter int unsigned MIN_VALID = DEF_MIN_VALID
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        gnt,
    output logic [N_REQ-1:0]        done,
    output logic [N_REQ-1:0]        timeout,
    output logic                    early_ack,
    bus_master_arbiter_if.master    bus
);

    localparam int unsigned IDX_W  = $clog2(N_REQ);
    localparam int unsigned VCNT_W = $clog2(MAX_VALID + 1);
    localparam logic [VCNT_W-1:0] VMIN = VCNT_W'(MIN_VALID);
    localparam logic [VCNT_W-1:0] VMAX = VCNT_W'(MAX_VALID);

    logic [0:0]        state_q, state_d;
    logic [VCNT_W-1:0] vcnt_q, vcnt_d;
    logic [IDX_W-1:0]  rr_q, rr_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              dvalid_q, dvalid_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [N_REQ-1:0]  done_q, done_d;
    logic [N_REQ-1:0]  timeout_q, timeout_d;
    logic              early_q, early_d;

    logic              pick_valid;
    logic [IDX_W-1:0]  pick_idx;
    logic [N_REQ-1:0]  pick_onehot;

    rr_picker #(
        .N_REQ (N_REQ)
    ) u_picker (
        .req    (req),
        .ptr    (rr_q),
        .valid  (pick_valid),
        .idx    (pick_idx),
        .onehot (pick_onehot)
    );

    always_comb begin
        state_d   = state_q;
        vcnt_d    = vcnt_q;
        rr_d      = rr_q;
        owner_d   = owner_q;
        data_d    = data_q;
        dvalid_d  = dvalid_q;
        early_d   = early_q;
        gnt_d     = '0;
        done_d    = '0;
        timeout_d = '0;

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d  = XFER;
                    dvalid_d = 1'b1;
                    data_d   = req_data[pick_idx*DATA_W +: DATA_W];
                    gnt_d    = pick_onehot;
                    vcnt_d   = VCNT_W'(1);
                    owner_d  = pick_idx;
                    rr_d     = IDX_W'(next_rr(int'(pick_idx), N_REQ));
                end
            end
            XFER: begin
                if (bus.dAck && vcnt_q >= VMIN) begin
                    state_d  = IDLE;
                    dvalid_d = 1'b0;
                    data_d   = '0;
                    vcnt_d   = '0;
                    done_d   = N_REQ'(1) << owner_q;
                end else begin
                    // Too-early ack is only flagged; the transfer keeps going.
                    if (bus.dAck) begin
                        early_d = 1'b1;
                    end
                    if (vcnt_q == VMAX) begin
                        state_d   = IDLE;
                        dvalid_d  = 1'b0;
                        data_d    = '0;
                        vcnt_d    = '0;
                        timeout_d = N_REQ'(1) << owner_q;
                    end else begin
                        vcnt_d = vcnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d  = IDLE;
                dvalid_d = 1'b0;
                data_d   = '0;
                vcnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            vcnt_q    <= '0;
            rr_q      <= '0;
            owner_q   <= '0;
            data_q    <= '0;
            dvalid_q  <= 1'b0;
            gnt_q     <= '0;
            done_q    <= '0;
            timeout_q <= '0;
            early_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            vcnt_q    <= vcnt_d;
            rr_q      <= rr_d;
            owner_q   <= owner_d;
            data_q    <= data_d;
            dvalid_q  <= dvalid_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            early_q   <= early_d;
        end
    end

    assign bus.dValid = dvalid_q;
    assign bus.data   = data_q;
    assign gnt        = gnt_q;
    assign done       = done_q;
    assign timeout    = timeout_q;
    assign early_ack  = early_q;

endmodule

// File: tb/tb_bus_master_arbiter.sv
module tb_bus_master_arbiter;

    localparam int N    = 4;
    localparam int W    = 8;
    localparam int MAXV = 4;
    localparam int MINV = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   gnt, done, timeout;
    logic           early_ack;

    bus_master_arbiter_if #(.DATA_W(W)) bus ();

    bus_master_arbiter #(
        .N_REQ     (N),
        .DATA_W    (W),
        .MAX_VALID (MAXV),
        .MIN_VALID (MINV)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_data  (req_data),
        .gnt       (gnt),
        .done      (done),
        .timeout   (timeout),
        .early_ack (early_ack),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: transfer-level view of the bus.
    bit         m_busy;
    int         m_owner, m_len, m_rr;
    logic [W-1:0] m_data;
    bit         m_early;
    logic [N-1:0] m_gnt, m_done, m_to;

    // Observed run lengths of dValid high / low.
    int hi_run = 0, lo_run = 0, last_len = 0, last_gap = 0;

    task automatic model_edge(input bit rst_n, input logic [N-1:0] r, input bit ack);
        int best, bestd, d;
        m_gnt = '0; m_done = '0; m_to = '0;
        if (!rst_n) begin
            m_busy = 0; m_len = 0; m_rr = 0; m_early = 0; m_data = '0; m_owner = 0;
        end else if (!m_busy) begin
            best = -1; bestd = N;
            // Winner: requester with the smallest circular distance from rr.
            for (int i = 0; i < N; i++) begin
                d = (i - m_rr + N) % N;
                if (r[i] && d < bestd) begin bestd = d; best = i; end
            end
            if (best >= 0) begin
                m_busy = 1; m_owner = best; m_len = 1;
                m_data = req_data[best*W +: W];
                m_gnt[best] = 1'b1;
                m_rr = (best + 1) % N;
            end
        end else begin
            if (ack && m_len >= MINV) begin
                m_busy = 0; m_data = '0; m_done[m_owner] = 1'b1;
            end else begin
                if (ack) m_early = 1;
                if (m_len == MAXV) begin
                    m_busy = 0; m_data = '0; m_to[m_owner] = 1'b1;
                end else begin
                    m_len++;
                end
            end
        end
    endtask

    task automatic step(input bit rst_n, input logic [N-1:0] r, input bit ack);
        reset    = rst_n;
        req      = r;
        bus.dAck = ack;
        model_edge(rst_n, r, ack);
        @(posedge clk);
        #1;
        check("dValid", 32'(bus.dValid), 32'(m_busy));
        check("data", 32'(bus.data), 32'(m_data));
        check("gnt", 32'(gnt), 32'(m_gnt));
        check("done", 32'(done), 32'(m_done));
        check("timeout", 32'(timeout), 32'(m_to));
        check("early_ack", 32'(early_ack), 32'(m_early));
        if (bus.dValid) begin
            if (hi_run == 0) last_gap = lo_run;
            hi_run++; lo_run = 0;
        end else begin
            if (hi_run != 0) last_len = hi_run;
            hi_run = 0; lo_run++;
        end
    endtask

    function automatic int onehot_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    int gq[$];
    int gapq[$];
    int exp_order[5] = '{0, 1, 2, 3, 0};

    initial begin
        reset = 1'b0; req = '0; req_data = '0; bus.dAck = 1'b0;
        step(0, 0, 0);
        step(0, 0, 1);

        // Single request, acked in vcnt=2.
        req_data[7:0] = 8'hA5;
        step(1, 4'b0001, 0);
        check("s1_gnt", 32'(gnt), 32'h1);
        step(1, 0, 0);
        check("s1_data", 32'(bus.data), 32'hA5);
        step(1, 0, 1);
        check("s1_done", 32'(done), 32'h1);
        check("s1_len", 32'(last_len), 32'd2);
        step(1, 0, 0);

        // No ack: timeout after MAX_VALID clocks.
        req_data[15:8] = 8'h3C;
        step(1, 4'b0010, 0);
        for (int i = 0; i < MAXV; i++) step(1, 0, 0);
        check("s2_timeout", 32'(timeout), 32'h2);
        check("s2_len", 32'(last_len), 32'(MAXV));
        step(1, 0, 0);

        // All requesting, ack in vcnt=3; fresh reset so rr starts at 0.
        step(0, 0, 0);
        req_data = 32'h44332211;
        gq.delete(); gapq.delete();
        for (int i = 0; i < 60 && gq.size() < 5; i++) begin
            step(1, 4'hF, bus.dValid && hi_run == 3);
            if (gnt != 0) begin
                gq.push_back(onehot_idx(gnt));
                gapq.push_back(last_gap);
            end
        end
        check("s3_count", 32'(gq.size()), 32'd5);
        for (int i = 0; i < gq.size() && i < 5; i++) begin
            check("s3_order", 32'(gq[i]), 32'(exp_order[i]));
            if (i > 0) check("s3_gap", 32'(gapq[i]), 32'd1);
        end
        for (int i = 0; i < 10 && bus.dValid; i++) step(1, 0, hi_run == 3);
        step(1, 0, 0);

        // Early ack in vcnt=1 and vcnt=2.
        step(1, 4'b0100, 0);
        step(1, 0, 1);
        step(1, 0, 1);
        check("s4_done", 32'(done), 32'h4);
        check("s4_early", 32'(early_ack), 32'h1);
        step(1, 0, 0);
        check("s4_sticky", 32'(early_ack), 32'h1);

        // Reset during vcnt=2, then requester 0 wins first.
        step(1, 4'b0100, 0);
        step(1, 0, 0);
        step(0, 0, 0);
        check("s5_dvalid", 32'(bus.dValid), 32'h0);
        check("s5_data", 32'(bus.data), 32'h0);
        check("s5_nodone", 32'(done | timeout), 32'h0);
        step(1, 4'hF, 0);
        check("s5_gnt", 32'(gnt), 32'h1);
        for (int i = 0; i < MAXV; i++) step(1, 0, 0);
        step(1, 0, 0);

        // dAck pulses while idle: nothing happens.
        for (int i = 0; i < 6; i++) step(1, 0, i[0]);
        check("s6_idle", 32'(bus.dValid), 32'h0);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            req_data = $urandom;
            step($urandom_range(0, 49) != 0, N'($urandom), $urandom_range(0, 9) < 4);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
